// File: rtl/sort_pkg.sv
// sort_pkg: shared types and default sizes for the sort scheduler,
// its arbiter, the sort engine and the benches.
package sort_pkg;

    localparam int SORT_DW      = 8;
    localparam int SORT_FRAME   = 6;
    localparam int SORT_TIMEOUT = 64;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_COLLECT = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_e;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin picker, purely combinational.
// Ports: i_req_a/i_req_b requests, i_last previous winner,
//        o_grant chosen requester, o_valid any request present.
module rr_arb2
    import sort_pkg::*;
(
    input  logic   i_req_a,
    input  logic   i_req_b,
    input  owner_e i_last,
    output owner_e o_grant,
    output logic   o_valid
);

    always_comb begin
        o_valid = i_req_a | i_req_b;
        if (i_req_a && i_req_b) begin
            // contention: the side that did not win last time goes next
            o_grant = (i_last == OWN_A) ? OWN_B : OWN_A;
        end else if (i_req_b) begin
            o_grant = OWN_B;
        end else begin
            o_grant = OWN_A;
        end
    end

endmodule

// File: rtl/sort_sched.sv
// sort_sched: round-robin sharing of one FRAME-beat sort engine between
// requesters A and B. Streams the owner's frame into the engine, routes
// the sorted beats back with a done pulse after the last one.
// Ports: clk, rst (sync, active-low); req_a/req_b, din_a/din_b from
//        requesters; gnt_a/gnt_b, res_vld_a/res_vld_b, res_data,
//        done_a/done_b, busy to requesters; sort_dv/sort_din to the
//        engine, sort_vld/sort_res from it.
// Optional: define SORT_SCHED_TIMEOUT_EN for a COLLECT watchdog and a
//        sticky err output (also flags sort_vld outside COLLECT).
module sort_sched
    import sort_pkg::*;
#(
    parameter int DW      = SORT_DW,
    parameter int FRAME   = SORT_FRAME
`ifdef SORT_SCHED_TIMEOUT_EN
    ,
    parameter int TIMEOUT = SORT_TIMEOUT
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_a,
    input  logic          req_b,
    input  logic [DW-1:0] din_a,
    input  logic [DW-1:0] din_b,
    output logic          gnt_a,
    output logic          gnt_b,
    output logic          sort_dv,
    output logic [DW-1:0] sort_din,
    input  logic          sort_vld,
    input  logic [DW-1:0] sort_res,
    output logic          res_vld_a,
    output logic          res_vld_b,
    output logic [DW-1:0] res_data,
    output logic          done_a,
    output logic          done_b,
    output logic          busy
`ifdef SORT_SCHED_TIMEOUT_EN
    ,
    output logic          err
`endif
);

    localparam int CW = (FRAME > 1) ? $clog2(FRAME) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(FRAME - 1);

    state_e        r_state;
    state_e        w_state_nxt;
    owner_e        r_owner;
    owner_e        r_last;
    logic [CW-1:0] r_in_cnt;
    logic [CW-1:0] r_out_cnt;
    logic          r_res_vld;
    logic [DW-1:0] r_res_data;

    owner_e        w_arb_gnt;
    logic          w_arb_vld;
    logic          w_collect_vld;
    logic          w_wd_fire;

    assign w_collect_vld = (r_state == ST_COLLECT) && sort_vld;

    rr_arb2 u_arb (
        .i_req_a (req_a),
        .i_req_b (req_b),
        .i_last  (r_last),
        .o_grant (w_arb_gnt),
        .o_valid (w_arb_vld)
    );

`ifdef SORT_SCHED_TIMEOUT_EN
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

    logic [WW-1:0] r_wd;
    logic          r_err;

    // counts consecutive idle COLLECT cycles; fires on the TIMEOUT-th
    assign w_wd_fire = (r_state == ST_COLLECT) && !sort_vld
                       && (r_wd == WD_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wd  <= '0;
            r_err <= 1'b0;
        end else begin
            if ((r_state == ST_COLLECT) && !sort_vld && !w_wd_fire)
                r_wd <= r_wd + WW'(1);
            else
                r_wd <= '0;
            if (w_wd_fire || (sort_vld && (r_state != ST_COLLECT)))
                r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign w_wd_fire = 1'b0;
`endif

    // state register and datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_owner    <= OWN_A;
            r_last     <= OWN_B;
            r_in_cnt   <= '0;
            r_out_cnt  <= '0;
            r_res_vld  <= 1'b0;
            r_res_data <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_res_vld <= 1'b0;

            if ((r_state == ST_IDLE) && w_arb_vld) begin
                r_owner <= w_arb_gnt;
                r_last  <= w_arb_gnt;
            end

            if ((r_state == ST_LOAD) && (r_in_cnt != LAST_BEAT))
                r_in_cnt <= r_in_cnt + CW'(1);
            else
                r_in_cnt <= '0;

            // gaps in sort_vld hold the beat count
            if (r_state != ST_COLLECT)
                r_out_cnt <= '0;
            else if (sort_vld)
                r_out_cnt <= (r_out_cnt == LAST_BEAT) ? '0
                             : r_out_cnt + CW'(1);

            if (w_collect_vld) begin
                r_res_vld  <= 1'b1;
                r_res_data <= sort_res;
            end
        end
    end

    // next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:
                if (w_arb_vld) w_state_nxt = ST_LOAD;
            ST_LOAD:
                if (r_in_cnt == LAST_BEAT) w_state_nxt = ST_COLLECT;
            ST_COLLECT:
                if ((sort_vld && (r_out_cnt == LAST_BEAT)) || w_wd_fire)
                    w_state_nxt = ST_DONE;
            ST_DONE:
                w_state_nxt = ST_IDLE;
            default:
                w_state_nxt = ST_IDLE;
        endcase
    end

    // outputs; done lines up with the last registered result beat
    always_comb begin
        gnt_a     = 1'b0;
        gnt_b     = 1'b0;
        sort_dv   = 1'b0;
        sort_din  = '0;
        done_a    = 1'b0;
        done_b    = 1'b0;
        busy      = (r_state != ST_IDLE);
        res_vld_a = r_res_vld && (r_owner == OWN_A);
        res_vld_b = r_res_vld && (r_owner == OWN_B);
        res_data  = r_res_data;
        if (r_state == ST_LOAD) begin
            sort_dv = 1'b1;
            if (r_owner == OWN_A) begin
                gnt_a    = 1'b1;
                sort_din = din_a;
            end else begin
                gnt_b    = 1'b1;
                sort_din = din_b;
            end
        end
        if (r_state == ST_DONE) begin
            done_a = (r_owner == OWN_A);
            done_b = (r_owner == OWN_B);
        end
    end

endmodule

// File: tb/tb_sort_sched.sv
// tb_sort_sched: randomized bench for sort_sched; the bench plays the
// sort engine and keeps a frame-level model of arbitration and results.
module tb_sort_sched;
    import sort_pkg::*;

    localparam int DW    = SORT_DW;
    localparam int FRAME = SORT_FRAME;
    localparam int TO    = SORT_TIMEOUT;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_a = 1'b0, req_b = 1'b0;
    logic [DW-1:0] din_a = '0, din_b = '0;
    logic          gnt_a, gnt_b, sort_dv;
    logic [DW-1:0] sort_din;
    logic          sort_vld = 1'b0;
    logic [DW-1:0] sort_res = '0;
    logic          res_vld_a, res_vld_b;
    logic [DW-1:0] res_data;
    logic          done_a, done_b, busy;
`ifdef SORT_SCHED_TIMEOUT_EN
    logic          err;
    bit            junk = 1'b0;
`else
    bit            junk = 1'b1;
`endif

    sort_sched dut (
        .clk       (clk),
        .rst       (rst),
        .req_a     (req_a),
        .req_b     (req_b),
        .din_a     (din_a),
        .din_b     (din_b),
        .gnt_a     (gnt_a),
        .gnt_b     (gnt_b),
        .sort_dv   (sort_dv),
        .sort_din  (sort_din),
        .sort_vld  (sort_vld),
        .sort_res  (sort_res),
        .res_vld_a (res_vld_a),
        .res_vld_b (res_vld_b),
        .res_data  (res_data),
        .done_a    (done_a),
        .done_b    (done_b),
        .busy      (busy)
`ifdef SORT_SCHED_TIMEOUT_EN
        ,
        .err       (err)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    bit m_last;
    int d[FRAME];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_frame();
        foreach (d[i]) d[i] = int'($urandom_range(255, 0));
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_gnt"}, {gnt_a, gnt_b, sort_dv}, 0);
        chk({tag, "_din"}, sort_din, 0);
        chk({tag, "_rv"}, {res_vld_a, res_vld_b}, 0);
        chk({tag, "_done"}, {done_a, done_b}, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req_a = 1'b0;
        req_b = 1'b0;
        sort_vld = 1'b0;
        tick();
        chk_quiet("rst");
        chk("rst_rdata", res_data, 0);
        rst = 1'b1;
        m_last = 1'b1;
    endtask

    // one complete frame; called and returning in an IDLE cycle
    task automatic frame(input bit ra, input bit rb, input bit hold,
                         input bit stall3, input bit pulse_b);
        bit own, prev, go;
        int n, j, gap;
        int q[$];
        own = (ra && rb) ? !m_last : rb;
        m_last = own;
        req_a = ra;
        req_b = rb;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(gnt_a || gnt_b) && n < 20);
        chk("gnt_lat", n, 1);
        for (int k = 0; k < FRAME; k++) begin
            if (k > 0) tick();
            if (!hold) begin
                req_a = 1'b0;
                req_b = 1'b0;
            end
            if (pulse_b) req_b = (k == 2);
            din_a = own ? DW'($urandom) : DW'(d[k]);
            din_b = own ? DW'(d[k]) : DW'($urandom);
            sort_vld = junk ? 1'($urandom) : 1'b0;
            sort_res = DW'($urandom);
            #1;
            chk("gnt_own", own ? gnt_b : gnt_a, 1);
            chk("gnt_oth", own ? gnt_a : gnt_b, 0);
            chk("sort_dv", sort_dv, 1);
            chk("sort_din", sort_din, d[k]);
            chk("busy_ld", busy, 1);
        end
        foreach (d[i]) q.push_back(d[i]);
        q.sort();
        j = 0;
        gap = 0;
        prev = 1'b0;
        n = 0;
        tick();
        while ((j < FRAME || prev) && n < 300) begin
            chk("rv_own", own ? res_vld_b : res_vld_a, prev);
            chk("rv_oth", own ? res_vld_a : res_vld_b, 0);
            if (prev) chk("rdata", res_data, q[j-1]);
            chk("done_own", own ? done_b : done_a, prev && j == FRAME);
            chk("done_oth", own ? done_a : done_b, 0);
            chk("col_dv", {gnt_a, gnt_b, sort_dv}, 0);
            chk("busy_col", busy, 1);
            go = (j < FRAME) && ($urandom_range(3, 0) != 0);
            if (stall3 && j == 2 && gap < 3) go = 1'b0;
            if (go) begin
                sort_vld = 1'b1;
                sort_res = DW'(q[j]);
                j++;
                gap = 0;
            end else begin
                sort_vld = 1'b0;
                sort_res = DW'($urandom);
                gap++;
            end
            prev = go;
            tick();
            n++;
        end
        chk("col_bound", n < 300, 1);
        chk("busy_idle", busy, 0);
        chk("idle_rv", {res_vld_a, res_vld_b, done_a, done_b}, 0);
    endtask

    initial begin
        int n;
        bit ra, rb;
        tick();
        do_reset();
`ifdef SORT_SCHED_TIMEOUT_EN
        chk("err_rst", err, 0);
`endif
        // directed frame for A
        d = '{5, 3, 9, 1, 7, 2};
        frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // both held from reset: A, B, A with one IDLE cycle between
        do_reset();
        for (int i = 0; i < 3; i++) begin
            rand_frame();
            frame(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        end

        // engine stall after the second result beat
        rand_frame();
        frame(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

        // req_b pulse during A's LOAD is lost
        rand_frame();
        frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        chk("lost_busy", busy, 0);
        chk("lost_gnt", gnt_b, 0);

        // reset on the third LOAD cycle
        req_a = 1'b1;
        tick();
        chk("ld1_gnt", gnt_a, 1);
        req_a = 1'b0;
        tick();
        tick();
        do_reset();
        rand_frame();
        frame(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // random traffic
        for (int i = 0; i < 12; i++) begin
            rand_frame();
            ra = 1'($urandom);
            rb = 1'($urandom);
            if (!ra && !rb) ra = 1'b1;
            frame(ra, rb, 1'b0, 1'($urandom), 1'b0);
        end

`ifdef SORT_SCHED_TIMEOUT_EN
        chk("err_clean", err, 0);
        req_a = 1'b1;
        m_last = 1'b0;
        tick();
        req_a = 1'b0;
        for (int k = 1; k < FRAME; k++) tick();
        sort_vld = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
            chk("to_rv", res_vld_a, 0);
        end while (!done_a && n < 200);
        chk("to_cycle", n, TO + 1);
        chk("to_err", err, 1);
        tick();
        chk("to_idle", busy, 0);
        rand_frame();
        frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("err_sticky", err, 1);
        do_reset();
        chk("err_clr", err, 0);
`else
        n = 0;
        chk("end_idle", busy, n);
`endif
        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
